aq_ifu_btb_wr_ctrl: RTL and testbench
=====================================

// Module: aq_ifu_btb_wr_ctrl
// PURPOSE
//  Write-side controller for the IFU BTB entry array. Accepts resolved-branch update/delete requests from BJU
//  and CP0 invalidate-all. Looks up the write tag against all entries, then drives the one-hot per-entry
//  update/clear strobes and gate enables, tag and target. Misses allocate a round-robin victim.
// PARAMETERS
//  ENTRY_NUM   16  number of BTB entries (power of 2)
//  ADDR_WIDTH  16  tag/target width, matches entry storage
// PORTS
//  forever_cpuclk       in   1           free-running core clock
//  cpurst               in   1           async reset, active-high
//  cp0_ifu_btb_en       in   1           BTB enable; 0 = accepted requests are dropped
//  cp0_ifu_btb_inv      in   1           invalidate-all pulse
//  btb_inv_done         out  1           1-cycle pulse, invalidate complete
//  bju_btb_upd_vld      in   1           request valid
//  bju_btb_upd_del      in   1           1 = delete (branch not taken), 0 = update/allocate
//  bju_btb_upd_tag      in   ADDR_WIDTH  branch PC tag
//  bju_btb_upd_tgt      in   ADDR_WIDTH  branch target
//  btb_bju_upd_rdy      out  1           request accepted when vld&rdy
//  btb_entry_wr_hit     in   ENTRY_NUM   per-entry hit against btb_wr_acc_tag (combinational from array)
//  btb_wr_acc_tag       out  ADDR_WIDTH  lookup tag to array
//  btb_entry_upd        out  ENTRY_NUM   one-hot entry write strobe
//  btb_entry_updg       out  ENTRY_NUM   entry clock-gate enable for write, equals btb_entry_upd
//  btb_entry_clr        out  ENTRY_NUM   entry invalidate strobe
//  btb_entry_clrg       out  ENTRY_NUM   entry clock-gate enable for clear, equals btb_entry_clr
//  btb_upd_tag          out  ADDR_WIDTH  write tag
//  btb_upd_tgt          out  ADDR_WIDTH  write target
// BEHAVIOUR
//  - FSM states: IDLE, LKUP, WRITE, INV. Reset state is IDLE. At reset: victim ptr=0, payload regs=0,
//    all strobes=0, btb_inv_done=0, btb_bju_upd_rdy=1.
//  - rdy = (state==IDLE) & ~cp0_ifu_btb_inv (combinational).
//  - Accept at cycle T. Capture tag, tgt, del and en=cp0_ifu_btb_en.
//  - LKUP (T+1): btb_wr_acc_tag = captured tag. Register hit vector; keep only the lowest-index hit
//    (one-hot).
//  - WRITE (T+2): strobes are valid for exactly 1 cycle; IDLE at T+3.
//      en=0                 -> no strobes
//      del=1 & hit          -> clr/clrg on the hit entry
//      del=1 & miss         -> no strobes
//      del=0 & hit          -> upd/updg on the hit entry (target refresh); ptr unchanged
//      del=0 & miss         -> upd/updg on entry[ptr]; ptr = ptr+1, wraps ENTRY_NUM-1 -> 0
//  - btb_upd_tag/tgt are driven from the payload regs. btb_wr_acc_tag holds the captured tag in every state.
//  - No entry is ever updated and cleared in the same cycle.
//  - Invalidate: cp0_ifu_btb_inv in any state -> INV next cycle.
//      In INV: clr and clrg are all-ones for 1 cycle; btb_inv_done pulses in the same cycle; ptr=0;
//      next state IDLE.
//      Any in-flight request is abandoned with no strobes; BJU must not expect completion.
//      Inv has priority over a simultaneous upd_vld (rdy=0, request not accepted).
//      Inv asserted while in INV re-enters INV (another clear cycle).
//  - Reset mid-operation: everything returns to reset values immediately (async); no strobes after deassert.
// STRUCTURE
//  - Shared define/package: FSM state encoding (2b), ENTRY_NUM, ADDR_WIDTH, and a one-hot lowest-set
//    priority function. Keep these common with the BTB read-side controller.
//  - Sub-module aq_ifu_btb_victim_ptr: round-robin counter with inc/clr inputs and one-hot decode output.
//  - Strobes are decoded from state plus registered vectors; no combinational path from bju_* to
//    btb_entry_*.
// TESTING
//  - Miss allocate: empty array, upd tag=0x1234 tgt=0x5678 at T
//      -> T+2: upd=0x0001, upd_tag=0x1234, upd_tgt=0x5678; ptr=1; rdy high at T+3.
//  - Hit refresh: wr_hit=0x0020 in LKUP, tgt=0x0AA0
//      -> upd=0x0020; ptr unchanged.
//  - Wrap: 16 consecutive misses then one more
//      -> 17th writes upd=0x0001; delete with wr_hit=0x0004 -> clr=0x0004, upd=0.
//  - Invalidate mid-request: inv pulse during LKUP
//      -> next cycle clr=clrg=0xFFFF and inv_done=1; no upd for that request; next miss writes 0x0001.
//  - Simultaneous inv and upd_vld in IDLE
//      -> rdy=0, only INV executes; with cp0_ifu_btb_en=0 the request completes with zero strobes.
//  - Async reset asserted during WRITE
//      -> all strobes drop the same cycle; after deassert rdy=1, state IDLE.

Source files
------------

// File: rtl/aq_ifu_btb_wr_ctrl_pkg.sv
// aq_ifu_btb_wr_ctrl_pkg: BTB geometry, FSM encoding and priority helper shared with the read-side controller
package aq_ifu_btb_wr_ctrl_pkg;
  localparam int ENTRY_NUM = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LKUP = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_INV = 2'd3;
  function automatic logic [ENTRY_NUM-1:0] lowest_onehot(input logic [ENTRY_NUM-1:0] v);
    return v & (~v + ENTRY_NUM'(1));
  endfunction
endpackage

// File: rtl/aq_ifu_btb_wr_ctrl_if.sv
// aq_ifu_btb_wr_ctrl_if: CP0/BJU request side and BTB entry-array side of the write controller
interface aq_ifu_btb_wr_ctrl_if;
  import aq_ifu_btb_wr_ctrl_pkg::*;
  logic                  cp0_ifu_btb_en;
  logic                  cp0_ifu_btb_inv;
  logic                  btb_inv_done;
  logic                  bju_btb_upd_vld;
  logic                  bju_btb_upd_del;
  logic [ADDR_WIDTH-1:0] bju_btb_upd_tag;
  logic [ADDR_WIDTH-1:0] bju_btb_upd_tgt;
  logic                  btb_bju_upd_rdy;
  logic [ENTRY_NUM-1:0]  btb_entry_wr_hit;
  logic [ADDR_WIDTH-1:0] btb_wr_acc_tag;
  logic [ENTRY_NUM-1:0]  btb_entry_upd;
  logic [ENTRY_NUM-1:0]  btb_entry_updg;
  logic [ENTRY_NUM-1:0]  btb_entry_clr;
  logic [ENTRY_NUM-1:0]  btb_entry_clrg;
  logic [ADDR_WIDTH-1:0] btb_upd_tag;
  logic [ADDR_WIDTH-1:0] btb_upd_tgt;
  modport slave (
    input  cp0_ifu_btb_en, cp0_ifu_btb_inv, bju_btb_upd_vld, bju_btb_upd_del,
           bju_btb_upd_tag, bju_btb_upd_tgt, btb_entry_wr_hit,
    output btb_inv_done, btb_bju_upd_rdy, btb_wr_acc_tag, btb_entry_upd, btb_entry_updg,
           btb_entry_clr, btb_entry_clrg, btb_upd_tag, btb_upd_tgt
  );
  modport master (
    output cp0_ifu_btb_en, cp0_ifu_btb_inv, bju_btb_upd_vld, bju_btb_upd_del,
           bju_btb_upd_tag, bju_btb_upd_tgt, btb_entry_wr_hit,
    input  btb_inv_done, btb_bju_upd_rdy, btb_wr_acc_tag, btb_entry_upd, btb_entry_updg,
           btb_entry_clr, btb_entry_clrg, btb_upd_tag, btb_upd_tgt
  );
endinterface

// File: rtl/aq_ifu_btb_wr_ctrl_victim_ptr.sv
// aq_ifu_btb_victim_ptr: round-robin allocation pointer with one-hot decode
module aq_ifu_btb_victim_ptr
  import aq_ifu_btb_wr_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ENTRY_NUM-1:0] ptr_oh
);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr ? '0 : inc ? ptr_q + 1'b1 : ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_oh = ENTRY_NUM'(1) << ptr_q;
endmodule

// File: rtl/aq_ifu_btb_wr_ctrl.sv
// aq_ifu_btb_wr_ctrl: BTB write-side controller; lookup, then one-hot update/clear strobes or invalidate-all
module aq_ifu_btb_wr_ctrl
  import aq_ifu_btb_wr_ctrl_pkg::*;
(
  input  logic                        forever_cpuclk,
  input  logic                        cpurst,
  aq_ifu_btb_wr_ctrl_if.slave         ifc
);
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d, tgt_q, tgt_d;
  logic                  del_q, del_d, en_q, en_d;
  logic [ENTRY_NUM-1:0]  hit_q, hit_d, vic_oh;
  logic                  inv, acc, wr, hit_any, ptr_inc, ptr_clr;
  always_comb begin
    inv = ifc.cp0_ifu_btb_inv;
    acc = ifc.bju_btb_upd_vld & (state_q == ST_IDLE) & ~inv;
    state_d = inv ? ST_INV :
              state_q == ST_IDLE ? (acc ? ST_LKUP : ST_IDLE) :
              state_q == ST_LKUP ? ST_WRITE : ST_IDLE;
    tag_d = acc ? ifc.bju_btb_upd_tag : tag_q;
    tgt_d = acc ? ifc.bju_btb_upd_tgt : tgt_q;
    del_d = acc ? ifc.bju_btb_upd_del : del_q;
    en_d = acc ? ifc.cp0_ifu_btb_en : en_q;
    hit_d = state_q == ST_LKUP ? lowest_onehot(ifc.btb_entry_wr_hit) : hit_q;
    // an invalidate arriving in WRITE abandons the request, so the write is squashed too
    wr = (state_q == ST_WRITE) & en_q & ~inv;
    hit_any = |hit_q;
    ptr_inc = wr & ~del_q & ~hit_any;
    ptr_clr = state_q == ST_INV;
  end
  always_ff @(posedge forever_cpuclk or posedge cpurst)
    if (cpurst) begin
      state_q <= ST_IDLE;
      tag_q <= '0;
      tgt_q <= '0;
      del_q <= 1'b0;
      en_q <= 1'b0;
      hit_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      del_q <= del_d;
      en_q <= en_d;
      hit_q <= hit_d;
    end
  aq_ifu_btb_victim_ptr u_victim_ptr (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .inc    (ptr_inc),
    .clr    (ptr_clr),
    .ptr_oh (vic_oh)
  );
  assign ifc.btb_bju_upd_rdy = (state_q == ST_IDLE) & ~inv;
  assign ifc.btb_wr_acc_tag = tag_q;
  assign ifc.btb_upd_tag = tag_q;
  assign ifc.btb_upd_tgt = tgt_q;
  assign ifc.btb_inv_done = state_q == ST_INV;
  assign ifc.btb_entry_upd = wr & ~del_q ? (hit_any ? hit_q : vic_oh) : '0;
  assign ifc.btb_entry_clr = state_q == ST_INV ? '1 : wr & del_q ? hit_q : '0;
  assign ifc.btb_entry_updg = ifc.btb_entry_upd;
  assign ifc.btb_entry_clrg = ifc.btb_entry_clr;
endmodule

// File: tb/tb_aq_ifu_btb_wr_ctrl.sv
// tb_aq_ifu_btb_wr_ctrl: randomized + directed checks against a BTB array/victim model
module tb_aq_ifu_btb_wr_ctrl;
  import aq_ifu_btb_wr_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aq_ifu_btb_wr_ctrl_if ifc();
  aq_ifu_btb_wr_ctrl dut (.forever_cpuclk(clk), .cpurst(rst), .ifc(ifc));
  int n_cmp = 0;
  int n_err = 0;
  logic                  m_vld [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] m_tag [ENTRY_NUM];
  int                    m_ptr;
  logic                  use_force;
  logic [ENTRY_NUM-1:0]  force_hit;
  logic [15:0]           got_upd, got_clr;
  always_comb begin
    ifc.btb_entry_wr_hit = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      ifc.btb_entry_wr_hit[i] = m_vld[i] && (m_tag[i] == ifc.btb_wr_acc_tag);
    if (use_force) ifc.btb_entry_wr_hit = force_hit;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic int model_hit(input logic [ADDR_WIDTH-1:0] tag);
    for (int i = 0; i < ENTRY_NUM; i++)
      if (use_force ? force_hit[i] : (m_vld[i] && m_tag[i] == tag)) return i;
    return -1;
  endfunction
  task automatic model_inv;
    for (int i = 0; i < ENTRY_NUM; i++) m_vld[i] = 1'b0;
    m_ptr = 0;
  endtask
  task automatic check_inv_cycle(input string name);
    check({name, "_clr"}, 32'(ifc.btb_entry_clr), 32'hFFFF);
    check({name, "_clrg"}, 32'(ifc.btb_entry_clrg), 32'hFFFF);
    check({name, "_done"}, 32'(ifc.btb_inv_done), 32'd1);
    check({name, "_upd"}, 32'(ifc.btb_entry_upd), 32'd0);
  endtask
  task automatic check_idle(input string name);
    check({name, "_rdy"}, 32'(ifc.btb_bju_upd_rdy), 32'd1);
    check({name, "_quiet"}, {ifc.btb_entry_upd, ifc.btb_entry_clr}, 32'd0);
    check({name, "_done"}, 32'(ifc.btb_inv_done), 32'd0);
  endtask
  task automatic do_req(input logic del, input logic [15:0] tag, input logic [15:0] tgt, input logic en);
    int h, w;
    logic [15:0] eu, ec;
    w = 0;
    while (!ifc.btb_bju_upd_rdy && w < 20) begin
      step;
      w++;
    end
    check("req_rdy", 32'(ifc.btb_bju_upd_rdy), 32'd1);
    ifc.bju_btb_upd_vld = 1'b1;
    ifc.bju_btb_upd_del = del;
    ifc.bju_btb_upd_tag = tag;
    ifc.bju_btb_upd_tgt = tgt;
    ifc.cp0_ifu_btb_en = en;
    step;
    ifc.bju_btb_upd_vld = 1'b0;
    ifc.bju_btb_upd_tag = 16'($urandom);
    ifc.cp0_ifu_btb_en = 1'($urandom);
    check("lkup_acc_tag", 32'(ifc.btb_wr_acc_tag), 32'(tag));
    check("lkup_rdy", 32'(ifc.btb_bju_upd_rdy), 32'd0);
    check("lkup_quiet", {ifc.btb_entry_upd, ifc.btb_entry_clr}, 32'd0);
    h = model_hit(tag);
    eu = '0;
    ec = '0;
    if (en && del && h >= 0) ec = 16'd1 << h;
    if (en && !del) eu = 16'd1 << (h >= 0 ? h : m_ptr);
    step;
    got_upd = ifc.btb_entry_upd;
    got_clr = ifc.btb_entry_clr;
    check("wr_upd", 32'(ifc.btb_entry_upd), 32'(eu));
    check("wr_updg", 32'(ifc.btb_entry_updg), 32'(eu));
    check("wr_clr", 32'(ifc.btb_entry_clr), 32'(ec));
    check("wr_clrg", 32'(ifc.btb_entry_clrg), 32'(ec));
    check("wr_tag", 32'(ifc.btb_upd_tag), 32'(tag));
    check("wr_tgt", 32'(ifc.btb_upd_tgt), 32'(tgt));
    if (en && del && h >= 0) m_vld[h] = 1'b0;
    if (en && !del) begin
      if (h < 0) begin
        h = m_ptr;
        m_ptr = (m_ptr + 1) % ENTRY_NUM;
      end
      m_vld[h] = 1'b1;
      m_tag[h] = tag;
    end
    step;
    check_idle("post_req");
  endtask
  task automatic do_inv(input int cycles);
    ifc.cp0_ifu_btb_inv = 1'b1;
    #1;
    check("inv_rdy", 32'(ifc.btb_bju_upd_rdy), 32'd0);
    for (int c = 0; c < cycles; c++) begin
      step;
      if (c == cycles - 1) ifc.cp0_ifu_btb_inv = 1'b0;
      check_inv_cycle("inv");
    end
    model_inv();
    step;
    check_idle("post_inv");
  endtask
  task automatic do_abort(input int phase);
    ifc.bju_btb_upd_vld = 1'b1;
    ifc.bju_btb_upd_del = 1'b0;
    ifc.bju_btb_upd_tag = 16'h7000 | 16'($urandom_range(0, 255));
    ifc.bju_btb_upd_tgt = 16'($urandom);
    ifc.cp0_ifu_btb_en = 1'b1;
    step;
    ifc.bju_btb_upd_vld = 1'b0;
    if (phase == 2) begin
      step;
      ifc.cp0_ifu_btb_inv = 1'b1;
      #1;
      check("abort_wr_quiet", {ifc.btb_entry_upd, ifc.btb_entry_clr}, 32'd0);
    end else ifc.cp0_ifu_btb_inv = 1'b1;
    step;
    ifc.cp0_ifu_btb_inv = 1'b0;
    check_inv_cycle("abort_inv");
    model_inv();
    step;
    check_idle("post_abort");
  endtask
  initial begin
    ifc.cp0_ifu_btb_en = 1'b1;
    ifc.cp0_ifu_btb_inv = 1'b0;
    ifc.bju_btb_upd_vld = 1'b0;
    ifc.bju_btb_upd_del = 1'b0;
    ifc.bju_btb_upd_tag = '0;
    ifc.bju_btb_upd_tgt = '0;
    use_force = 1'b0;
    force_hit = '0;
    model_inv();
    for (int i = 0; i < ENTRY_NUM; i++) m_tag[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_tag", 32'(ifc.btb_upd_tag), 32'd0);
    check("reset_tgt", 32'(ifc.btb_upd_tgt), 32'd0);
    check("reset_acc", 32'(ifc.btb_wr_acc_tag), 32'd0);
    rst = 1'b0;
    step;
    do_req(1'b0, 16'h1234, 16'h5678, 1'b1);
    check("first_miss", 32'(got_upd), 32'h0001);
    use_force = 1'b1;
    force_hit = 16'h0020;
    do_req(1'b0, 16'h4444, 16'h0AA0, 1'b1);
    check("hit_refresh", 32'(got_upd), 32'h0020);
    force_hit = 16'h00A0;
    do_req(1'b0, 16'h4545, 16'h0BB0, 1'b1);
    check("hit_lowest", 32'(got_upd), 32'h0020);
    use_force = 1'b0;
    do_req(1'b0, 16'h5555, 16'h0CC0, 1'b1);
    check("ptr_unchanged", 32'(got_upd), 32'h0002);
    do_inv(1);
    for (int i = 0; i < 17; i++) do_req(1'b0, 16'h2000 + 16'(i), 16'h3000 + 16'(i), 1'b1);
    check("wrap_17th", 32'(got_upd), 32'h0001);
    use_force = 1'b1;
    force_hit = 16'h0004;
    do_req(1'b1, 16'h2002, 16'h0000, 1'b1);
    check("del_clr", 32'(got_clr), 32'h0004);
    check("del_no_upd", 32'(got_upd), 32'h0000);
    use_force = 1'b0;
    do_req(1'b1, 16'h9999, 16'h0000, 1'b1);
    check("del_miss", {got_upd, got_clr}, 32'd0);
    do_abort(1);
    do_req(1'b0, 16'h6666, 16'h1111, 1'b1);
    check("after_abort", 32'(got_upd), 32'h0001);
    ifc.bju_btb_upd_vld = 1'b1;
    ifc.bju_btb_upd_tag = 16'hABCD;
    ifc.cp0_ifu_btb_inv = 1'b1;
    #1;
    check("simul_rdy", 32'(ifc.btb_bju_upd_rdy), 32'd0);
    step;
    ifc.bju_btb_upd_vld = 1'b0;
    ifc.cp0_ifu_btb_inv = 1'b0;
    check_inv_cycle("simul_inv");
    model_inv();
    step;
    check_idle("simul_post");
    step;
    check_idle("simul_no_req");
    do_req(1'b0, 16'h7777, 16'h2222, 1'b0);
    check("en0_quiet", {got_upd, got_clr}, 32'd0);
    do_abort(2);
    do_inv(2);
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_inv($urandom_range(1, 2));
      else if (r == 1) do_abort($urandom_range(1, 2));
      else do_req($urandom_range(0, 3) == 0, 16'h1000 + 16'($urandom_range(0, 23)),
                  16'($urandom), $urandom_range(0, 7) != 0);
    end
    ifc.bju_btb_upd_vld = 1'b1;
    ifc.bju_btb_upd_del = 1'b0;
    ifc.bju_btb_upd_tag = 16'hEEEE;
    ifc.cp0_ifu_btb_en = 1'b1;
    step;
    ifc.bju_btb_upd_vld = 1'b0;
    step;
    check("rst_pre_upd", 32'(ifc.btb_entry_upd), 32'(16'd1 << m_ptr));
    #2 rst = 1'b1;
    #1;
    check("rst_upd", 32'(ifc.btb_entry_upd), 32'd0);
    check("rst_updg", 32'(ifc.btb_entry_updg), 32'd0);
    check("rst_clr", 32'(ifc.btb_entry_clr), 32'd0);
    check("rst_rdy", 32'(ifc.btb_bju_upd_rdy), 32'd1);
    #2 rst = 1'b0;
    m_ptr = 0;
    step;
    check_idle("post_rst");
    do_req(1'b0, 16'hF00D, 16'hBEEF, 1'b1);
    check("post_rst_miss", 32'(got_upd), 32'h0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
